// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC priority select and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the fetch_cnt / bubble_cnt performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] IRQ_VEC  = 32'h80000004,
  parameter logic [31:0] EXC_VEC  = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [25:0] jump_index,
  input  logic        jr_taken,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] epc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] jump_pc;
  logic [31:0] jr_pc;
  logic        irq_take;
  logic        redirect;
  logic        bubble_load;
  logic        fetch_load;

  assign pc_plus4 = pc_reg + 32'd4;
  assign rom_addr = pc_reg;

  // An interrupt is only accepted from user mode; kernel-mode requests are dropped.
  assign irq_take = irq & ~pc_reg[31] & ~exc;
  assign redirect = exc | irq_take | jr_taken | jump_taken | branch_taken;

  // Register jumps may leave kernel mode but can never enter it.
  assign jr_pc   = {jr_target[31] & pc_reg[31], jr_target[30:0]};
  assign jump_pc = {ifid_pc_plus4[31:28], jump_index, 2'b00};

  assign bubble_load = redirect | flush;
  assign fetch_load  = ~bubble_load & ~stall;

  always_comb begin
    pc_next = pc_plus4;
    if (exc)               pc_next = EXC_VEC;
    else if (irq_take)     pc_next = IRQ_VEC;
    else if (jr_taken)     pc_next = jr_pc;
    else if (jump_taken)   pc_next = jump_pc;
    else if (branch_taken) pc_next = branch_target;
    else if (stall)        pc_next = pc_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr    <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (bubble_load) begin
      ifid_instr    <= 32'd0;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b0;
    end else if (fetch_load) begin
      ifid_instr    <= rom_data;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
    end
  end

  // Exceptions resume at the faulting instruction in ID; interrupts at the PC not yet fetched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc <= 32'd0;
    end else if (exc) begin
      epc <= ifid_pc_plus4 - 32'd4;
    end else if (irq_take) begin
      epc <= pc_reg;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (fetch_load)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (bubble_load) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized run
// against a behavioural next-PC / IF-ID model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam logic [31:0] IRQ_VEC  = 32'h80000004;
  localparam logic [31:0] EXC_VEC  = 32'h80000008;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken, jump_taken, jr_taken, irq, exc;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] rom_addr, rom_data;
  logic [31:0] ifid_instr, ifid_pc_plus4, epc;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pp4, m_epc, m_fcnt, m_bcnt;
  logic        m_valid;
  logic [31:0] n_pc, n_instr, n_pp4, n_epc, n_fcnt, n_bcnt;
  logic        n_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign rom_data = rom_word(rom_addr);

  if_fetch_stage #(.RESET_PC(RESET_PC), .IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_taken(jump_taken), .jump_index(jump_index),
    .jr_taken(jr_taken), .jr_target(jr_target),
    .irq(irq), .exc(exc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .epc(epc)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic clear_ctl();
    stall = 0; flush = 0; branch_taken = 0; jump_taken = 0; jr_taken = 0;
    irq = 0; exc = 0; branch_target = 0; jr_target = 0; jump_index = 0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_epc = 0;
    m_fcnt = 0; m_bcnt = 0;
  endtask

  // Next state from the priority rules: exc > user-mode irq > jr > j > branch > stall > +4
  task automatic model_next();
    logic irq_ok;
    logic kill;
    irq_ok = irq && !m_pc[31] && !exc;
    kill = exc || irq_ok || jr_taken || jump_taken || branch_taken || flush;
    if (exc)               n_pc = EXC_VEC;
    else if (irq_ok)       n_pc = IRQ_VEC;
    else if (jr_taken)     n_pc = (jr_target[31] && m_pc[31]) ? jr_target : (jr_target & 32'h7FFF_FFFF);
    else if (jump_taken)   n_pc = (m_pp4 & 32'hF000_0000) | (32'(jump_index) * 4);
    else if (branch_taken) n_pc = branch_target;
    else if (stall)        n_pc = m_pc;
    else                   n_pc = m_pc + 4;
    n_fcnt = m_fcnt; n_bcnt = m_bcnt;
    if (kill) begin
      n_instr = 0; n_valid = 0; n_pp4 = m_pc + 4; n_bcnt = m_bcnt + 1;
    end else if (stall) begin
      n_instr = m_instr; n_valid = m_valid; n_pp4 = m_pp4;
    end else begin
      n_instr = rom_word(m_pc); n_valid = 1; n_pp4 = m_pc + 4; n_fcnt = m_fcnt + 1;
    end
    if (exc)         n_epc = m_pp4 - 4;
    else if (irq_ok) n_epc = m_pc;
    else             n_epc = m_epc;
  endtask

  task automatic cycle();
    model_next();
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid; m_epc = n_epc;
    m_fcnt = n_fcnt; m_bcnt = n_bcnt;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    clear_ctl();
    branch_taken = 1; branch_target = target;
    cycle();
    clear_ctl();
  endtask

  task automatic test_reset();
    clear_ctl();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
    repeat (3) cycle();
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    tests++;
    if (rom_addr !== RESET_PC || ifid_instr !== 0 || ifid_pc_plus4 !== 0 ||
        ifid_valid !== 0 || epc !== 0) begin
      fails++;
      $display("FAIL reset_async: pc=%h instr=%h pp4=%h valid=%b epc=%h expected pc=%h others 0",
               rom_addr, ifid_instr, ifid_pc_plus4, ifid_valid, epc, RESET_PC);
    end
`ifdef IF_PERF_CNT_EN
    tests++;
    if (fetch_cnt !== 0 || bubble_cnt !== 0) begin
      fails++;
      $display("FAIL reset_cnt: fetch=%0d bubble=%0d expected 0 0", fetch_cnt, bubble_cnt);
    end
`endif
    @(posedge clk);
    #1 reset = 0;
    $display("[TB] reset: pc=%h", rom_addr);
  endtask

  task automatic test_boot();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h80000000; exp_addr[1] = 32'h80000004; exp_addr[2] = 32'h80000008;
    clear_ctl();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rom_addr !== exp_addr[i] || ifid_valid !== (i > 0)) begin
        fails++;
        $display("FAIL boot_seq[%0d]: rom_addr=%h valid=%b expected %h %b",
                 i, rom_addr, ifid_valid, exp_addr[i], i > 0);
      end
      if (i > 0) begin
        tests++;
        if (ifid_instr !== rom_word(exp_addr[i-1]) || ifid_pc_plus4 !== exp_addr[i]) begin
          fails++;
          $display("FAIL boot_ifid[%0d]: instr=%h pp4=%h expected %h %h",
                   i, ifid_instr, ifid_pc_plus4, rom_word(exp_addr[i-1]), exp_addr[i]);
        end
      end
      $display("[TB] boot: rom_addr=%h valid=%b", rom_addr, ifid_valid);
      cycle();
    end
  endtask

  task automatic test_stall();
    goto_pc(32'h30);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (rom_addr !== 32'h30 || ifid_instr !== 0 || ifid_valid !== 0 || ifid_pc_plus4 !== m_pp4) begin
        fails++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h valid=%b pp4=%h expected 30 0 0 %h",
                 i, rom_addr, ifid_instr, ifid_valid, ifid_pc_plus4, m_pp4);
      end
    end
    stall = 0;
    cycle();
    tests++;
    if (rom_addr !== 32'h34 || ifid_instr !== rom_word(32'h30) || ifid_valid !== 1) begin
      fails++;
      $display("FAIL stall_release: pc=%h instr=%h valid=%b expected 34 %h 1",
               rom_addr, ifid_instr, ifid_valid, rom_word(32'h30));
    end
    $display("[TB] stall: pc=%h", rom_addr);
  endtask

  task automatic test_jump();
    goto_pc(32'h0C);
    cycle();
    jump_taken = 1; jump_index = 26'h18;
    cycle();
    clear_ctl();
    tests++;
    if (rom_addr !== 32'h60 || ifid_valid !== 0 || ifid_instr !== 0) begin
      fails++;
      $display("FAIL jump: pc=%h valid=%b instr=%h expected 60 0 0", rom_addr, ifid_valid, ifid_instr);
    end
    $display("[TB] jump: pc=%h", rom_addr);
  endtask

  task automatic test_irq();
    goto_pc(32'h5C);
    irq = 1;
    cycle();
    clear_ctl();
    tests++;
    if (rom_addr !== IRQ_VEC || epc !== 32'h5C || ifid_valid !== 0) begin
      fails++;
      $display("FAIL irq_take: pc=%h epc=%h valid=%b expected %h 5c 0", rom_addr, epc, ifid_valid, IRQ_VEC);
    end
    goto_pc(32'h80000010);
    irq = 1;
    cycle();
    clear_ctl();
    tests++;
    if (rom_addr !== 32'h80000014 || epc !== 32'h5C || ifid_valid !== 1) begin
      fails++;
      $display("FAIL irq_kernel: pc=%h epc=%h valid=%b expected 80000014 5c 1", rom_addr, epc, ifid_valid);
    end
    $display("[TB] irq: pc=%h epc=%h", rom_addr, epc);
  endtask

  task automatic test_exc_priority();
    goto_pc(32'h20);
    cycle();
    exc = 1; irq = 1; branch_taken = 1; branch_target = 32'h100; stall = 1;
    cycle();
    clear_ctl();
    tests++;
    if (rom_addr !== EXC_VEC || epc !== 32'h20 || ifid_valid !== 0) begin
      fails++;
      $display("FAIL exc_priority: pc=%h epc=%h valid=%b expected %h 20 0", rom_addr, epc, ifid_valid, EXC_VEC);
    end
    $display("[TB] exc: pc=%h epc=%h", rom_addr, epc);
  endtask

  task automatic test_jr();
    goto_pc(32'h80000040);
    jr_taken = 1; jr_target = 32'h0C;
    cycle();
    clear_ctl();
    tests++;
    if (rom_addr !== 32'h0C) begin
      fails++;
      $display("FAIL jr_to_user: pc=%h expected 0000000c", rom_addr);
    end
    goto_pc(32'h40);
    jr_taken = 1; jr_target = 32'h80000000;
    cycle();
    clear_ctl();
    tests++;
    if (rom_addr !== 32'h0) begin
      fails++;
      $display("FAIL jr_no_kernel: pc=%h expected 00000000", rom_addr);
    end
    $display("[TB] jr: pc=%h", rom_addr);
  endtask

  task automatic test_reset_mid_redirect();
    goto_pc(32'h50);
    stall = 1; branch_taken = 1; branch_target = 32'h44;
    #2 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    clear_ctl();
    model_reset();
    tests++;
    if (rom_addr !== RESET_PC || ifid_valid !== 0) begin
      fails++;
      $display("FAIL reset_redirect: pc=%h valid=%b expected %h 0", rom_addr, ifid_valid, RESET_PC);
    end
    cycle();
    tests++;
    if (rom_addr !== RESET_PC + 4 || ifid_instr !== rom_word(RESET_PC) || ifid_valid !== 1) begin
      fails++;
      $display("FAIL reset_first_fetch: pc=%h instr=%h valid=%b expected %h %h 1",
               rom_addr, ifid_instr, ifid_valid, RESET_PC + 4, rom_word(RESET_PC));
    end
    $display("[TB] reset mid-redirect: pc=%h", rom_addr);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump_taken    = ($urandom_range(0, 9) == 0);
      jr_taken      = ($urandom_range(0, 9) == 0);
      irq           = ($urandom_range(0, 5) == 0);
      exc           = ($urandom_range(0, 19) == 0);
      branch_target = $urandom & 32'h8000_00FC;
      jr_target     = $urandom & 32'h8000_0FFC;
      jump_index    = 26'($urandom);
      cycle();
      tests++;
      if (rom_addr !== m_pc || ifid_instr !== m_instr || ifid_pc_plus4 !== m_pp4 ||
          ifid_valid !== m_valid || epc !== m_epc) begin
        fails++;
        $display("FAIL random[%0d]: pc=%h instr=%h pp4=%h v=%b epc=%h expected %h %h %h %b %h",
                 i, rom_addr, ifid_instr, ifid_pc_plus4, ifid_valid, epc,
                 m_pc, m_instr, m_pp4, m_valid, m_epc);
      end
`ifdef IF_PERF_CNT_EN
      tests++;
      if (fetch_cnt !== m_fcnt || bubble_cnt !== m_bcnt) begin
        fails++;
        $display("FAIL random_cnt[%0d]: fetch=%0d bubble=%0d expected %0d %0d",
                 i, fetch_cnt, bubble_cnt, m_fcnt, m_bcnt);
      end
`endif
      $display("[TB] rand %0d: pc=%h valid=%b epc=%h", i, rom_addr, ifid_valid, epc);
    end
    clear_ctl();
  endtask

  initial begin
    reset = 1;
    clear_ctl();
    model_reset();
    test_reset();
    test_boot();
    test_stall();
    test_jump();
    test_irq();
    test_exc_priority();
    test_jr();
    test_reset_mid_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
